// File: rtl/scan_frame_sequencer_if.sv
// Bus bundle between the scan sequencer, the memory_share client port and the DAC driver.
// master = sequencer side, slave = memory/DAC side.
interface scan_frame_sequencer_if;
  logic [31:0] mem_addr;
  logic        mem_we;
  logic [31:0] mem_rdata;
  logic [11:0] pt_x;
  logic [11:0] pt_y;
  logic        pt_laser;
  logic        pt_valid;
  logic        pt_ready;

  modport master (
    output mem_addr, mem_we, pt_x, pt_y, pt_laser, pt_valid,
    input  mem_rdata, pt_ready
  );

  modport slave (
    input  mem_addr, mem_we, pt_x, pt_y, pt_laser, pt_valid,
    output mem_rdata, pt_ready
  );
endinterface

// File: rtl/scan_frame_sequencer.sv
// Ping-pong point-list scanner: fetches packed points from the front bank and hands them to the DAC.
// Optional blanked settle presentation before off->on points: define SCAN_BLANK_SETTLE_EN.
//
// state         | meaning
// S_IDLE        | parked, blanked; waits for enable
// S_FETCH       | address of current point on mem_addr
// S_CAPTURE     | latch x/y/laser/eof from mem_rdata
// S_SETTLE      | blanked presentation of new point (optional feature)
// S_SETTLE_WAIT | blanked settle countdown (optional feature)
// S_PRESENT     | pt_valid high until pt_ready
// S_DWELL       | hold point, count down, then advance
module scan_frame_sequencer #(
  parameter logic [31:0] BANK0_BASE    = 32'd0,
  parameter logic [31:0] BANK1_BASE    = 32'd1024,
  parameter int          MAX_POINTS    = 256,
  parameter int          DWELL_CYCLES  = 100,
  parameter int          SETTLE_CYCLES = 20
) (
  input  logic clk,
  input  logic reset_n,
  input  logic enable,
  input  logic swap_req,
  output logic swap_ack,
  output logic front_bank,
  output logic frame_start,
  output logic overrun,
  scan_frame_sequencer_if.master bus
);

  localparam int IDX_W   = (MAX_POINTS > 1) ? $clog2(MAX_POINTS) : 1;
  localparam int CNT_MAX = (DWELL_CYCLES > SETTLE_CYCLES) ? DWELL_CYCLES : SETTLE_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(MAX_POINTS - 1);
  localparam logic [CNT_W-1:0] DWELL_LOAD = CNT_W'(DWELL_CYCLES - 1);
`ifdef SCAN_BLANK_SETTLE_EN
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
`endif

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_CAPTURE, S_PRESENT, S_DWELL, S_SETTLE, S_SETTLE_WAIT
  } state_t;

  state_t           state_q, state_n;
  logic [IDX_W-1:0] index_q, index_n;
  logic [CNT_W-1:0] cnt_q, cnt_n;
  logic [11:0]      x_q, x_n, y_q, y_n;
  logic             laser_q, laser_n, eof_q, eof_n;
  logic             front_q, front_n, pending_q, pending_n;
  logic             overrun_q, overrun_n, ack_q, ack_n, fstart_q, fstart_n;
  logic             frame_end;
`ifdef SCAN_BLANK_SETTLE_EN
  logic             prev_laser_q, prev_laser_n;
`endif

  // Reserved word bits 30:25 carry no meaning for the scanner.
  logic unused_rdata;
  assign unused_rdata = ^bus.mem_rdata[30:25];

  assign frame_end = eof_q || (index_q == LAST_IDX);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      index_q   <= '0;
      cnt_q     <= '0;
      x_q       <= '0;
      y_q       <= '0;
      laser_q   <= 1'b0;
      eof_q     <= 1'b0;
      front_q   <= 1'b0;
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
      ack_q     <= 1'b0;
      fstart_q  <= 1'b0;
`ifdef SCAN_BLANK_SETTLE_EN
      prev_laser_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_n;
      index_q   <= index_n;
      cnt_q     <= cnt_n;
      x_q       <= x_n;
      y_q       <= y_n;
      laser_q   <= laser_n;
      eof_q     <= eof_n;
      front_q   <= front_n;
      pending_q <= pending_n;
      overrun_q <= overrun_n;
      ack_q     <= ack_n;
      fstart_q  <= fstart_n;
`ifdef SCAN_BLANK_SETTLE_EN
      prev_laser_q <= prev_laser_n;
`endif
    end
  end

  always_comb begin
    state_n   = state_q;
    index_n   = index_q;
    cnt_n     = cnt_q;
    x_n       = x_q;
    y_n       = y_q;
    laser_n   = laser_q;
    eof_n     = eof_q;
    front_n   = front_q;
    pending_n = pending_q | swap_req;
    overrun_n = overrun_q;
    ack_n     = 1'b0;
    fstart_n  = 1'b0;
`ifdef SCAN_BLANK_SETTLE_EN
    prev_laser_n = prev_laser_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (enable) begin
          state_n  = S_FETCH;
          fstart_n = (index_q == '0);
        end
      end
      S_FETCH: state_n = S_CAPTURE;
      S_CAPTURE: begin
        x_n     = bus.mem_rdata[11:0];
        y_n     = bus.mem_rdata[23:12];
        laser_n = bus.mem_rdata[24];
        eof_n   = bus.mem_rdata[31];
        state_n = S_PRESENT;
`ifdef SCAN_BLANK_SETTLE_EN
        if (bus.mem_rdata[24] && !prev_laser_q) state_n = S_SETTLE;
`endif
      end
`ifdef SCAN_BLANK_SETTLE_EN
      S_SETTLE: begin
        if (bus.pt_ready) begin
          cnt_n   = SETTLE_LOAD;
          state_n = S_SETTLE_WAIT;
        end
      end
      S_SETTLE_WAIT: begin
        if (cnt_q == '0) state_n = S_PRESENT;
        else             cnt_n   = cnt_q - 1'b1;
      end
`endif
      S_PRESENT: begin
        if (bus.pt_ready) begin
          cnt_n   = DWELL_LOAD;
          state_n = S_DWELL;
`ifdef SCAN_BLANK_SETTLE_EN
          prev_laser_n = laser_q;
`endif
        end
      end
      S_DWELL: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - 1'b1;
        end else begin
          state_n = enable ? S_FETCH : S_IDLE;
          if (frame_end) begin
            index_n = '0;
            if (!eof_q) overrun_n = 1'b1;
            // A request arriving on this very clock is folded into this swap.
            if (pending_q || swap_req) begin
              front_n   = ~front_q;
              ack_n     = 1'b1;
              pending_n = 1'b0;
            end
            fstart_n = enable;
          end else begin
            index_n = index_q + 1'b1;
          end
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  assign bus.mem_addr = (front_q ? BANK1_BASE : BANK0_BASE) + 32'({index_q, 2'b00});
  assign bus.mem_we   = 1'b0;
  assign bus.pt_x     = x_q;
  assign bus.pt_y     = y_q;
  assign bus.pt_valid = (state_q == S_PRESENT) || (state_q == S_SETTLE);
  assign bus.pt_laser = enable && laser_q && ((state_q == S_PRESENT) || (state_q == S_DWELL));

  assign swap_ack    = ack_q;
  assign front_bank  = front_q;
  assign frame_start = fstart_q;
  assign overrun     = overrun_q;

endmodule

// File: tb/tb_scan_frame_sequencer.sv
// Directed bench for scan_frame_sequencer with a 1-clock-latency memory model (DWELL_CYCLES = 4).
module tb_scan_frame_sequencer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic enable = 1'b0;
  logic swap_req = 1'b0;
  logic swap_ack, front_bank, frame_start, overrun;
  int checks = 0;
  int failures = 0;
  int n;
  int acks;
  logic [31:0] mem [0:511];

  scan_frame_sequencer_if bus();

  scan_frame_sequencer #(.DWELL_CYCLES(4)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .swap_req    (swap_req),
    .swap_ack    (swap_ack),
    .front_bank  (front_bank),
    .frame_start (frame_start),
    .overrun     (overrun),
    .bus         (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) bus.mem_rdata <= mem[bus.mem_addr[10:2]];

  function automatic logic [31:0] word(input int x, input int y, input bit laser, input bit eof);
    return {eof, 6'b0, laser, y[11:0], x[11:0]};
  endfunction

  task automatic step(input int cycles);
    repeat (cycles) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'd0;
    mem[0]   = word(1, 2, 1'b1, 1'b0);
    mem[1]   = word(3, 4, 1'b0, 1'b0);
    mem[2]   = word(5, 6, 1'b1, 1'b1);
    mem[256] = word(100, 200, 1'b1, 1'b0);
    mem[257] = word(101, 201, 1'b1, 1'b1);
    bus.pt_ready = 1'b1;
    enable = 1'b1;

    // reset values
    step(2);
    chk("reset_outs", {swap_ack, front_bank, frame_start, overrun, bus.pt_valid, bus.pt_laser, bus.mem_we}, 64'd0);
    chk("reset_addr", bus.mem_addr, 64'd0);
    chk("reset_pt", {bus.pt_x, bus.pt_y}, 64'd0);

    // 3-point frame in bank 0, 7-clock point period
    reset_n = 1'b1;
    step(1); chk("t1_fetch0", {frame_start, bus.mem_addr}, {1'b1, 32'd0});
    step(1); chk("t1_capture_fs", frame_start, 64'd0);
    step(1); chk("t1_present0", {bus.pt_valid, bus.pt_laser, bus.pt_x, bus.pt_y}, {1'b1, 1'b1, 12'd1, 12'd2});
    step(1); chk("t1_dwell0", {bus.pt_valid, bus.pt_laser, bus.pt_x}, {1'b0, 1'b1, 12'd1});
    step(4); chk("t1_fetch1", {frame_start, bus.mem_addr}, {1'b0, 32'd4});
    step(7); chk("t1_fetch2", {frame_start, bus.mem_addr}, {1'b0, 32'd8});
    step(2); chk("t1_present2", {bus.pt_valid, bus.pt_x, bus.pt_y}, {1'b1, 12'd5, 12'd6});
    step(5); chk("t1_wrap", {frame_start, bus.mem_addr, overrun}, {1'b1, 32'd0, 1'b0});

    // DAC stalls for 10 clocks in PRESENT
    bus.pt_ready = 1'b0;
    step(2);
    for (int i = 0; i < 10; i++) begin
      chk("t3_stall", {bus.pt_valid, bus.pt_x, bus.pt_y, bus.mem_addr}, {1'b1, 12'd1, 12'd2, 32'd0});
      step(1);
    end
    bus.pt_ready = 1'b1;
    step(1); chk("t3_release", bus.pt_valid, 64'd0);

    // two swap requests in one bank-0 frame -> one swap at the frame end
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    step(1);
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    n = 0;
    while (!swap_ack && n < 40) begin
      step(1);
      n++;
    end
    chk("t4_ack_time", n, 64'd15);
    chk("t4_swap", {front_bank, frame_start, bus.mem_addr}, {1'b1, 1'b1, 32'd1024});
    step(1); chk("t4_ack_pulse", swap_ack, 64'd0);
    acks = 0;
    for (int i = 0; i < 13; i++) begin
      step(1);
      acks += int'(swap_ack);
    end
    chk("t4_single_swap", acks, 64'd0);
    chk("t4_frame1", {front_bank, frame_start, bus.mem_addr}, {1'b1, 1'b1, 32'd1024});

    // enable dropped during a lit dwell
    step(3); chk("t5_lit", {bus.pt_laser, bus.pt_x}, {1'b1, 12'd100});
    enable = 1'b0;
    #1 chk("t5_blank_now", {bus.pt_laser, bus.pt_x}, {1'b0, 12'd100});
    step(4); chk("t5_idle", {bus.pt_valid, frame_start, bus.mem_addr}, {1'b0, 1'b0, 32'd1028});
    step(5); chk("t5_parked", {bus.pt_laser, bus.mem_addr}, {1'b0, 32'd1028});
    enable = 1'b1;
    step(1); chk("t5_resume", {frame_start, bus.mem_addr}, {1'b0, 32'd1028});
    step(2); chk("t5_present1", {bus.pt_valid, bus.pt_laser, bus.pt_x, bus.pt_y}, {1'b1, 1'b1, 12'd101, 12'd201});

    // reset mid-dwell with a swap pending
    step(1);
    swap_req = 1'b1; step(1); swap_req = 1'b0;
    reset_n = 1'b0;
    #1 chk("t6_reset", {swap_ack, front_bank, frame_start, overrun, bus.pt_valid, bus.pt_laser,
                        bus.pt_x, bus.pt_y, bus.mem_addr}, 64'd0);
    step(1);
    reset_n = 1'b1;
    step(1); chk("t6_refetch", {front_bank, frame_start, bus.mem_addr}, {1'b0, 1'b1, 32'd0});

    // bank 0 with no EOF wraps at MAX_POINTS and sets sticky overrun
    mem[2] = word(5, 6, 1'b1, 1'b0);
    step(255 * 7); chk("t2_last", {bus.mem_addr, overrun}, {32'd1020, 1'b0});
    step(7); chk("t2_wrap", {frame_start, overrun, front_bank, swap_ack, bus.mem_addr},
                 {1'b1, 1'b1, 1'b0, 1'b0, 32'd0});
    step(30); chk("t2_sticky", overrun, 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/scan_frame_sequencer.md
Name: scan_frame_sequencer

Overview:
- Sequences the client port of memory_share as a ping-pong point-list frame buffer for the laser projector.
- Host (Beta) writes a frame of packed points into the back bank through the host port, then requests a swap.
- The sequencer fetches points from the front bank, presents each to the galvo/DAC driver with a valid/ready handshake, and holds each point for a fixed dwell.
- Swaps take effect only at a frame boundary, so the scanner never shows a torn frame.

Parameters:
- BANK0_BASE, 0, byte address of bank 0 word 0.
- BANK1_BASE, 1024, byte address of bank 1 word 0.
- MAX_POINTS, 256, points per bank. Forced wrap if no end-of-frame (EOF) flag is found.
- DWELL_CYCLES, 100, clocks each point is held after handshake (>=1).
- SETTLE_CYCLES, 20, extra blanked clocks used by the optional feature.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- enable  in  1  run scanning; low = blank and park
- swap_req  in  1  one-cycle pulse: back bank complete, swap at next frame end
- swap_ack  out  1  one-cycle pulse when a swap is performed
- front_bank  out  1  bank currently scanned (0/1)
- mem_addr  out  32  byte address to memory_share client_addr
- mem_we  out  1  to mwe_client, constant 0
- mem_rdata  in  32  from memory_share client_dout
- pt_x  out  12  point X (word bits 11:0)
- pt_y  out  12  point Y (word bits 23:12)
- pt_laser  out  1  laser on (word bit 24)
- pt_valid  out  1  point available to DAC driver
- pt_ready  in  1  DAC driver accepts point
- frame_start  out  1  one-cycle pulse when point 0 of a frame is fetched
- overrun  out  1  sticky: a bank wrapped at MAX_POINTS without EOF (word bit 31)

Behaviour:
- Reset values (async, reset_n low):
  - outputs: all 0; mem_addr = BANK0_BASE.
  - state: IDLE, index = 0, swap_pending = 0.
- mem_addr = (front_bank ? BANK1_BASE : BANK0_BASE) + 4*index.
- memory_share read latency is 1 clock; mem_rdata is sampled exactly one clock after mem_addr is set.
- States:
  - IDLE: pt_valid = 0, pt_laser = 0. When enable is high, go to FETCH; pulse frame_start if index = 0.
  - FETCH: drive mem_addr for 1 clock, then go to CAPTURE.
  - CAPTURE: register x, y, laser and eof from mem_rdata; go to PRESENT.
  - PRESENT: pt_valid = 1 and data held stable until pt_ready. On the handshake clock, go to DWELL with the counter loaded to DWELL_CYCLES-1.
  - DWELL: pt_valid = 0, pt_x/pt_y/pt_laser held. Count down to 0, then advance.
- Advance rules:
  - eof = 1 or index = MAX_POINTS-1: frame end.
    - If index = MAX_POINTS-1 and eof = 0, set overrun.
    - index = 0.
    - If swap_pending: toggle front_bank, pulse swap_ack, clear swap_pending.
    - Go to FETCH and pulse frame_start.
  - Otherwise index+1, then FETCH.
- swap_req:
  - Sets swap_pending in any state. Repeated requests before a frame end collapse into one.
  - swap_req in the same clock as a frame end is honoured at that frame end.
- Frame-to-frame point timing: 1 fetch + 1 capture + handshake + DWELL_CYCLES clocks.
- enable deasserted:
  - pt_laser is forced 0 combinationally at once.
  - The current point completes its handshake/dwell, then the block goes to IDLE.
  - index and front_bank are retained; re-enable resumes at the next point.
- overrun clears only on reset.
- Reset mid-frame: immediate return to reset values. A pending swap is lost.

Optional Feature:
- Macro: SCAN_BLANK_SETTLE_EN.
- Defined: when a captured point has laser = 1 and the previous presented point had laser = 0, insert a SETTLE state before PRESENT.
  - Lasts SETTLE_CYCLES clocks.
  - pt_valid = 1 with the new x/y and pt_laser = 0, handshaked like PRESENT. The counter starts after the handshake.
  - Then PRESENT presents the same point with laser = 1.
- Undefined: no SETTLE state; laser off→on points are presented directly.

Test Plan:
- Reset, enable = 1, bank0 holds 3 points with EOF on word 2, pt_ready = 1, DWELL_CYCLES = 4 → mem_addr sequence 0, 4, 8, 0, 4…; frame_start once per 3 points; point period = 7 clocks.
- Bank0 without any EOF, MAX_POINTS = 256 → wraps after address 1020, overrun = 1 and stays 1.
- swap_req mid-frame while bank1 holds 2 points → swap_ack exactly at bank0 frame end; next mem_addr = 1024; front_bank = 1; two swap_reqs in one frame give a single swap.
- pt_ready held low 10 clocks during PRESENT → pt_valid, pt_x, pt_y stable all 10 clocks; no address advance.
- enable dropped during DWELL of point 1 (laser = 1) → pt_laser = 0 the same clock; IDLE after dwell; re-enable fetches point 2.
- Assert reset_n low mid-DWELL → all outputs 0 asynchronously; after release, first fetch at BANK0_BASE. With SCAN_BLANK_SETTLE_EN, an off→on point shows a blanked presentation of SETTLE_CYCLES before the lit one.
